clock_divider: RTL and testbench



---
 rtl/clock_divider_if.sv | 9 +
 rtl/clock_divider.sv | 69 ++++++
 tb/tb_clock_divider.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clock_divider_if.sv
// rtl/clock_divider_if.sv - divided-clock output bundle for the alarm-clock divider
interface clock_divider_if;
  logic clk_1hz;
  logic clk_fast;
  logic clk_blink;

  modport master (output clk_1hz, output clk_fast, output clk_blink);
  modport slave  (input  clk_1hz, input  clk_fast, input  clk_blink);
endinterface

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - three independent 50% duty dividers from the board clock
// Each output register flips every HALF_x master edges; outputs come straight from flops.
module clock_divider #(
  parameter int HALF_1HZ   = 50_000_000,
  parameter int HALF_FAST  = 100_000,
  parameter int HALF_BLINK = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  clock_divider_if.master  o_div
);

  localparam int W_1HZ   = (HALF_1HZ   > 1) ? $clog2(HALF_1HZ)   : 1;
  localparam int W_FAST  = (HALF_FAST  > 1) ? $clog2(HALF_FAST)  : 1;
  localparam int W_BLINK = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;

  localparam logic [W_1HZ-1:0]   LAST_1HZ   = W_1HZ'(HALF_1HZ - 1);
  localparam logic [W_FAST-1:0]  LAST_FAST  = W_FAST'(HALF_FAST - 1);
  localparam logic [W_BLINK-1:0] LAST_BLINK = W_BLINK'(HALF_BLINK - 1);

  // Power-up values match the reset state so an unreset board behaves identically.
  logic [W_1HZ-1:0]   r_cnt_1hz   = '0;
  logic [W_FAST-1:0]  r_cnt_fast  = '0;
  logic [W_BLINK-1:0] r_cnt_blink = '0;
  logic               r_clk_1hz   = 1'b0;
  logic               r_clk_fast  = 1'b0;
  logic               r_clk_blink = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_1hz <= '0;
      r_clk_1hz <= 1'b0;
    end else if (r_cnt_1hz == LAST_1HZ) begin
      r_cnt_1hz <= '0;
      r_clk_1hz <= ~r_clk_1hz;
    end else begin
      r_cnt_1hz <= r_cnt_1hz + W_1HZ'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_fast <= '0;
      r_clk_fast <= 1'b0;
    end else if (r_cnt_fast == LAST_FAST) begin
      r_cnt_fast <= '0;
      r_clk_fast <= ~r_clk_fast;
    end else begin
      r_cnt_fast <= r_cnt_fast + W_FAST'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_blink <= '0;
      r_clk_blink <= 1'b0;
    end else if (r_cnt_blink == LAST_BLINK) begin
      r_cnt_blink <= '0;
      r_clk_blink <= ~r_clk_blink;
    end else begin
      r_cnt_blink <= r_cnt_blink + W_BLINK'(1);
    end
  end

  assign o_div.clk_1hz   = r_clk_1hz;
  assign o_div.clk_fast  = r_clk_fast;
  assign o_div.clk_blink = r_clk_blink;

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - directed bench for clock_divider (H = 10/2/5 and a HALF_FAST=1 variant)
module tb_clock_divider;

  logic clk;
  logic rst;
  logic clk_run;
  int   n_checks;
  int   n_errors;

  clock_divider_if if_a ();
  clock_divider_if if_b ();

  clock_divider #(.HALF_1HZ(10), .HALF_FAST(2), .HALF_BLINK(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .o_div (if_a)
  );

  clock_divider #(.HALF_1HZ(3), .HALF_FAST(1), .HALF_BLINK(4)) dut_h1 (
    .clk   (clk),
    .rst   (rst),
    .o_div (if_b)
  );

  initial begin
    clk     = 1'b0;
    clk_run = 1'b1;
    #100;
    forever begin
      if (clk_run) begin
        clk = 1'b1;
        #10;
        clk = 1'b0;
        #10;
      end else begin
        #20;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic model(input int k, input int h);
    return logic'((k / h) % 2);
  endfunction

  // Samples every edge after a release and compares all six outputs against the toggle count.
  task automatic run_and_check(input int n_edges, input string phase);
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_fast_e%0d", phase, k),     if_a.clk_fast,  model(k, 2));
      check($sformatf("%s_blink_e%0d", phase, k),    if_a.clk_blink, model(k, 5));
      check($sformatf("%s_1hz_e%0d", phase, k),      if_a.clk_1hz,   model(k, 10));
      check($sformatf("%s_h1fast_e%0d", phase, k),   if_b.clk_fast,  model(k, 1));
      check($sformatf("%s_h1blink_e%0d", phase, k),  if_b.clk_blink, model(k, 4));
      check($sformatf("%s_h1slow_e%0d", phase, k),   if_b.clk_1hz,   model(k, 3));
    end
  endtask

  typedef struct {
    int   edge_n;
    logic fast;
    logic blink;
    logic slow;
  } vec_t;

  vec_t vecs[12];
  int   hi_fast;
  int   hi_blink;
  int   hi_slow;
  int   hi_h1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    vecs[0]  = '{1,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{6,  1'b1, 1'b1, 1'b0};
    vecs[5]  = '{9,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{10, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{12, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{15, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{19, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{20, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{22, 1'b1, 1'b0, 1'b0};

    #50;
    check("pwrup_fast",  if_a.clk_fast,  1'b0);
    check("pwrup_blink", if_a.clk_blink, 1'b0);
    check("pwrup_1hz",   if_a.clk_1hz,   1'b0);
    check("pwrup_h1",    if_b.clk_fast,  1'b0);

    // Power-up without reset: hand-computed snapshot table
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("pu_h1fast_e%0d", e), if_b.clk_fast, logic'(e % 2));
      foreach (vecs[i]) begin
        if (vecs[i].edge_n == e) begin
          check($sformatf("pu_fast_e%0d", e),  if_a.clk_fast,  vecs[i].fast);
          check($sformatf("pu_blink_e%0d", e), if_a.clk_blink, vecs[i].blink);
          check($sformatf("pu_1hz_e%0d", e),   if_a.clk_1hz,   vecs[i].slow);
        end
      end
    end

    // Duty over 40 edges (a whole number of periods for every output)
    hi_fast = 0; hi_blink = 0; hi_slow = 0; hi_h1 = 0;
    for (int e = 23; e <= 62; e++) begin
      @(posedge clk);
      #1;
      hi_fast  += int'(if_a.clk_fast);
      hi_blink += int'(if_a.clk_blink);
      hi_slow  += int'(if_a.clk_1hz);
      hi_h1    += int'(if_b.clk_fast);
    end
    check("duty_fast",  logic'(hi_fast  == 20), 1'b1);
    check("duty_blink", logic'(hi_blink == 20), 1'b1);
    check("duty_1hz",   logic'(hi_slow  == 20), 1'b1);
    check("duty_h1",    logic'(hi_h1    == 20), 1'b1);
    check("pre_rst_fast", if_a.clk_fast, 1'b1);

    // Mid-period reset with clk high
    #4;
    rst = 1'b1;
    #1;
    check("rst_async_fast",  if_a.clk_fast,  1'b0);
    check("rst_async_blink", if_a.clk_blink, 1'b0);
    check("rst_async_1hz",   if_a.clk_1hz,   1'b0);
    check("rst_async_h1",    if_b.clk_fast,  1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold_fast_c%0d", c),  if_a.clk_fast,  1'b0);
      check($sformatf("rst_hold_blink_c%0d", c), if_a.clk_blink, 1'b0);
      check($sformatf("rst_hold_1hz_c%0d", c),   if_a.clk_1hz,   1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_and_check(15, "rel");

    // Reset with the clock stopped: only the asynchronous path can clear
    clk_run = 1'b0;
    #60;
    check("static_pre_fast",  if_a.clk_fast,  1'b1);
    check("static_pre_blink", if_a.clk_blink, 1'b1);
    check("static_pre_1hz",   if_a.clk_1hz,   1'b1);
    rst = 1'b1;
    #1;
    check("static_rst_fast",  if_a.clk_fast,  1'b0);
    check("static_rst_blink", if_a.clk_blink, 1'b0);
    check("static_rst_1hz",   if_a.clk_1hz,   1'b0);
    #20;
    rst = 1'b0;
    #20;
    clk_run = 1'b1;
    run_and_check(10, "rel2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
